// File: rtl/br_predictor_bht_if.sv
// Fetch-side query, execute-side update and counter outputs of the BHT predictor.
// The master modport belongs to the fetch/execute side that drives the predictor.
interface br_predictor_bht_if;
   logic [31:0] instruction_i;
   logic [31:0] pc_i;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic        miss_pred_i;
   logic        br_pred_o;
   logic [31:0] new_pc_pred_o;
   logic [31:0] br_cnt_o;
   logic [31:0] miss_cnt_o;

   modport master (
      output instruction_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, miss_pred_i,
      input  br_pred_o, new_pc_pred_o, br_cnt_o, miss_cnt_o
   );

   modport slave (
      input  instruction_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, miss_pred_i,
      output br_pred_o, new_pc_pred_o, br_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/br_predictor_bht.sv
// Bimodal branch predictor: 2^IDX_W two-bit saturating counters indexed by PC[IDX_W+1:2],
// combinational next-PC prediction plus resolved-branch and misprediction counters.
module br_predictor_bht #(
   parameter int unsigned IDX_W    = 6,
   parameter logic [1:0]  CNT_INIT = 2'b10,
   parameter bit          JAL_PRED = 1'b1
) (
   input logic               clk_i,
   input logic               rst_i,
   br_predictor_bht_if.slave bus
);
   localparam int unsigned DEPTH = 1 << IDX_W;

   logic [1:0]       r_cnt [DEPTH];
   logic [31:0]      r_br_cnt;
   logic [31:0]      r_miss_cnt;

   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic             w_is_br;
   logic             w_is_jal;
   logic [31:0]      w_imm_b;
   logic [31:0]      w_imm_j;
   logic [IDX_W-1:0] w_rd_idx;
   logic [IDX_W-1:0] w_upd_idx;
   logic [1:0]       w_upd_cur;
   logic [1:0]       w_upd_nxt;
   logic             w_pred;
   logic [31:0]      w_tgt;

   assign w_opcode  = bus.instruction_i[6:0];
   assign w_funct3  = bus.instruction_i[14:12];
   assign w_rd_idx  = bus.pc_i[IDX_W+1:2];
   assign w_upd_idx = bus.upd_pc_i[IDX_W+1:2];

   assign w_is_br  = (w_opcode == 7'b1100011) && (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
   assign w_is_jal = JAL_PRED && (w_opcode == 7'b1101111);

   assign w_imm_b = {{19{bus.instruction_i[31]}}, bus.instruction_i[31], bus.instruction_i[7],
                     bus.instruction_i[30:25], bus.instruction_i[11:8], 1'b0};
   assign w_imm_j = {{11{bus.instruction_i[31]}}, bus.instruction_i[31], bus.instruction_i[19:12],
                     bus.instruction_i[20], bus.instruction_i[30:21], 1'b0};

   // Prediction reads the registered table only, so a same-cycle update is seen next cycle.
   always_comb begin
      w_pred = 1'b0;
      w_tgt  = bus.pc_i + 32'd4;
      if (w_is_br) begin
         w_pred = r_cnt[w_rd_idx][1];
         if (w_pred) begin
            w_tgt = bus.pc_i + w_imm_b;
         end
      end else if (w_is_jal) begin
         w_pred = 1'b1;
         w_tgt  = bus.pc_i + w_imm_j;
      end
   end

   always_comb begin
      w_upd_cur = r_cnt[w_upd_idx];
      w_upd_nxt = w_upd_cur;
      if (bus.upd_taken_i) begin
         if (w_upd_cur != 2'b11) w_upd_nxt = w_upd_cur + 2'b01;
      end else begin
         if (w_upd_cur != 2'b00) w_upd_nxt = w_upd_cur - 2'b01;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_cnt[i] <= CNT_INIT;
         end
         r_br_cnt   <= '0;
         r_miss_cnt <= '0;
      end else if (bus.upd_valid_i) begin
         r_cnt[w_upd_idx] <= w_upd_nxt;
         r_br_cnt         <= r_br_cnt + 32'd1;
         if (bus.miss_pred_i) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign bus.br_pred_o     = w_pred;
   assign bus.new_pc_pred_o = w_tgt;
   assign bus.br_cnt_o      = r_br_cnt;
   assign bus.miss_cnt_o    = r_miss_cnt;
endmodule

// File: tb/tb_br_predictor_bht.sv
// Scoreboard bench for br_predictor_bht: expectations queued at drive time, checked mid-cycle.
module tb_br_predictor_bht;
   logic clk;
   logic rst;

   br_predictor_bht_if bif ();

   br_predictor_bht #(
      .IDX_W    (6),
      .CNT_INIT (2'b10),
      .JAL_PRED (1'b1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        sbq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [1:0]  m_cnt [64];
   logic [31:0] m_br;
   logic [31:0] m_miss;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] JALR = 32'h0000_8067;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
      return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
   endfunction

   // Reference prediction: returns {taken, next_pc} from the bench's own counter table.
   function automatic logic [32:0] mpred(input logic [31:0] inst, input logic [31:0] pc);
      logic [31:0] ib;
      logic [31:0] ij;
      ib = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      ij = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      if (inst[6:0] == 7'b1100011 && inst[14:12] != 3'b010 && inst[14:12] != 3'b011) begin
         if (m_cnt[pc[7:2]][1]) return {1'b1, pc + ib};
         return {1'b0, pc + 32'd4};
      end
      if (inst[6:0] == 7'b1101111) return {1'b1, pc + ij};
      return {1'b0, pc + 32'd4};
   endfunction

   task automatic expect_out(input int sel, input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sbq.push_back(e);
   endtask

   task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic miss,
                       input logic r, input bit use_model);
      logic [32:0] p;
      exp_t        e;
      logic [31:0] obs;
      bif.instruction_i = inst;
      bif.pc_i          = pc;
      bif.upd_valid_i   = uv;
      bif.upd_pc_i      = upc;
      bif.upd_taken_i   = ut;
      bif.miss_pred_i   = miss;
      rst               = r;
      if (use_model) begin
         p = mpred(inst, pc);
         expect_out(0, "mdl_pred", {31'd0, p[32]});
         expect_out(1, "mdl_npc", p[31:0]);
         expect_out(2, "mdl_brcnt", m_br);
         expect_out(3, "mdl_misscnt", m_miss);
      end
      @(negedge clk);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.sel)
            0:       obs = {31'd0, bif.br_pred_o};
            1:       obs = bif.new_pc_pred_o;
            2:       obs = bif.br_cnt_o;
            default: obs = bif.miss_cnt_o;
         endcase
         check_val(e.tag, obs, e.exp);
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 64; i++) m_cnt[i] = 2'b10;
         m_br   = '0;
         m_miss = '0;
      end else if (uv) begin
         if (ut && m_cnt[upc[7:2]] != 2'b11) m_cnt[upc[7:2]] = m_cnt[upc[7:2]] + 2'b01;
         if (!ut && m_cnt[upc[7:2]] != 2'b00) m_cnt[upc[7:2]] = m_cnt[upc[7:2]] - 2'b01;
         m_br = m_br + 32'd1;
         if (miss) m_miss = m_miss + 32'd1;
      end
      #1;
   endtask

   initial begin
      logic [31:0] beq16;
      logic [31:0] bne16;
      logic [31:0] beqm8;
      logic [31:0] bf010;
      logic [31:0] jal8;
      beq16 = enc_b(13'd16, 3'b000);
      bne16 = enc_b(13'd16, 3'b001);
      beqm8 = enc_b(-13'sd8, 3'b000);
      bf010 = enc_b(13'd16, 3'b010);
      jal8  = enc_j(21'd8);
      for (int i = 0; i < 64; i++) m_cnt[i] = 2'bxx;
      m_br   = 'x;
      m_miss = 'x;

      // reset, then BEQ predicts taken to pc+16
      step(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out(0, "rst_pred", 32'd1);
      expect_out(1, "rst_npc", 32'h110);
      expect_out(2, "rst_brcnt", 32'd0);
      expect_out(3, "rst_misscnt", 32'd0);
      step(beq16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      expect_out(1, "neg_imm_npc", 32'hF8);
      step(beqm8, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // invalid update must be ignored
      step(NOP, 32'h0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_out(0, "ign_pred", 32'd1);
      expect_out(2, "ign_brcnt", 32'd0);
      expect_out(3, "ign_misscnt", 32'd0);
      step(beq16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // two not-taken updates drive counter to 00, third saturates
      step(NOP, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
      step(NOP, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "nt2_pred", 32'd0);
      expect_out(1, "nt2_npc", 32'h104);
      step(beq16, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "nt3_sat_pred", 32'd0);
      step(beq16, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_out(0, "nt3_up1_pred", 32'd0);
      step(beq16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // upward saturation at 11
      step(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) step(NOP, 32'h0, 1'b1, 32'h140, 1'b1, 1'b0, 1'b0, 1'b1);
      step(NOP, 32'h0, 1'b1, 32'h140, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "sat_hi_pred", 32'd1);
      expect_out(1, "sat_hi_npc", 32'h150);
      step(beq16, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // same-cycle read and update: old value predicts
      step(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_out(0, "byp_same_pred", 32'd1);
      step(beq16, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "byp_next_pred", 32'd0);
      step(beq16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // aliasing 0x200 onto 0x100
      step(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(NOP, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
      step(NOP, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "alias_pred", 32'd0);
      expect_out(1, "alias_npc", 32'h104);
      step(bne16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // JAL wrap, JALR, reserved funct3
      expect_out(0, "jal_pred", 32'd1);
      expect_out(1, "jal_npc", 32'h4);
      step(jal8, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "jalr_pred", 32'd0);
      expect_out(1, "jalr_npc", 32'h44);
      step(JALR, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "f010_pred", 32'd0);
      expect_out(1, "f010_npc", 32'h144);
      step(bf010, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      // counters, then an update discarded by reset
      step(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(NOP, 32'h0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
      step(NOP, 32'h0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1);
      step(NOP, 32'h0, 1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_out(2, "cnt_br3", 32'd3);
      expect_out(3, "cnt_miss2", 32'd2);
      step(NOP, 32'h0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
      expect_out(2, "cnt_br_rst", 32'd0);
      expect_out(3, "cnt_miss_rst", 32'd0);
      expect_out(0, "init_pred_100", 32'd1);
      step(beq16, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "init_pred_104", 32'd1);
      step(beq16, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "init_pred_108", 32'd1);
      step(beq16, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
